// File: rtl/dmem_responder_if.sv
// Data-port bus between the single-cycle core and dmem_responder.
// The core drives address, lane enables and write data; the responder
// returns registered read data one cycle later.
interface dmem_responder_if;
    logic [31:0] d_addr;
    logic [3:0]  d_we;
    logic [31:0] d_wr_data;
    logic [31:0] d_rd_data;

    modport master (output d_addr, d_we, d_wr_data, input d_rd_data);
    modport slave  (input d_addr, d_we, d_wr_data, output d_rd_data);
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: data-side memory responder for the single-cycle core.
// Decodes every address into a byte-lane RAM, a 64-byte MMIO window
// (GPIO, machine timer, status) or unmapped space, and returns registered
// read data one cycle after the address is presented.
// Optional feature macro: DMEM_TIMER_EN (machine timer, mtimecmp, LO/HI
// snapshot shadow and timer_irq). Without it the timer offsets are unmapped
// and timer_irq is tied low.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus,
    input  logic [31:0]      gpio_in,
    output logic [31:0]      gpio_out,
    output logic             timer_irq,
    output logic             bad_addr
);

    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) << 2;

    localparam logic [3:0] OFF_GPIO_OUT    = 4'h0;
    localparam logic [3:0] OFF_GPIO_IN     = 4'h1;
    localparam logic [3:0] OFF_MTIME_LO    = 4'h2;
    localparam logic [3:0] OFF_MTIME_HI    = 4'h3;
    localparam logic [3:0] OFF_MTIMECMP_LO = 4'h4;
    localparam logic [3:0] OFF_MTIMECMP_HI = 4'h5;
    localparam logic [3:0] OFF_STATUS      = 4'h6;

    // Replace only the byte lanes selected by we.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  we);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (we[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0] d_rd_data_q, d_rd_data_d;
    logic [31:0] gpio_out_q,  gpio_out_d;
    logic        bad_addr_q,  bad_addr_d;
    logic [31:0] gpio_sync1_q, gpio_sync2_q;

    logic          ram_hit;
    logic          mmio_win;
    logic [3:0]    mmio_off;
    logic [AW-1:0] ram_idx;
    logic [31:0]   ram_rd_word;
    logic [3:0]    ram_we;
    logic          bad_set;
    logic          bad_clr;

`ifdef DMEM_TIMER_EN
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic [31:0] mtime_hi_shadow_q, mtime_hi_shadow_d;
    logic        timer_irq_q, timer_irq_d;
`endif

    assign ram_hit     = {1'b0, bus.d_addr} < RAM_BYTES;
    assign mmio_win    = bus.d_addr[31:6] == MMIO_BASE[31:6];
    assign mmio_off    = bus.d_addr[5:2];
    assign ram_idx     = bus.d_addr[AW+1:2];
    assign ram_rd_word = mem[ram_idx];

    // Address decode, read mux and next-state for every register; the RAM
    // word is read before the edge so a same-cycle write returns old data.
    always_comb begin
        d_rd_data_d = '0;
        gpio_out_d  = gpio_out_q;
        ram_we      = '0;
        bad_set     = 1'b0;
        bad_clr     = 1'b0;
`ifdef DMEM_TIMER_EN
        mtime_d           = mtime_q + 64'd1;
        mtimecmp_d        = mtimecmp_q;
        mtime_hi_shadow_d = mtime_hi_shadow_q;
        timer_irq_d       = mtime_q >= mtimecmp_q;
`endif
        if (ram_hit) begin
            d_rd_data_d = ram_rd_word;
            ram_we      = bus.d_we;
        end else if (mmio_win) begin
            case (mmio_off)
                OFF_GPIO_OUT: begin
                    d_rd_data_d = gpio_out_q;
                    gpio_out_d  = merge_lanes(gpio_out_q, bus.d_wr_data, bus.d_we);
                end
                OFF_GPIO_IN: begin
                    d_rd_data_d = gpio_sync2_q;
                end
`ifdef DMEM_TIMER_EN
                OFF_MTIME_LO: begin
                    d_rd_data_d       = mtime_q[31:0];
                    mtime_hi_shadow_d = mtime_q[63:32];
                    if (|bus.d_we) begin
                        mtime_d = {mtime_q[63:32],
                                   merge_lanes(mtime_q[31:0], bus.d_wr_data, bus.d_we)};
                    end
                end
                OFF_MTIME_HI: begin
                    d_rd_data_d = mtime_hi_shadow_q;
                    if (|bus.d_we) begin
                        mtime_d = {merge_lanes(mtime_q[63:32], bus.d_wr_data, bus.d_we),
                                   mtime_q[31:0]};
                    end
                end
                OFF_MTIMECMP_LO: begin
                    d_rd_data_d      = mtimecmp_q[31:0];
                    mtimecmp_d[31:0] = merge_lanes(mtimecmp_q[31:0], bus.d_wr_data, bus.d_we);
                end
                OFF_MTIMECMP_HI: begin
                    d_rd_data_d       = mtimecmp_q[63:32];
                    mtimecmp_d[63:32] = merge_lanes(mtimecmp_q[63:32], bus.d_wr_data, bus.d_we);
                end
`endif
                OFF_STATUS: begin
                    d_rd_data_d = {31'b0, bad_addr_q};
                    bad_clr     = bus.d_we[0] & bus.d_wr_data[0];
                end
                default: begin
                    bad_set = 1'b1;
                end
            endcase
        end else begin
            bad_set = 1'b1;
        end
        // A new fault in the same cycle as a clear must not be lost.
        bad_addr_d = bad_set | (bad_addr_q & ~bad_clr);
    end

    // RAM write port; gated by reset so a write caught by reset is dropped.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst && ram_we[i]) mem[ram_idx][8*i +: 8] <= bus.d_wr_data[8*i +: 8];
        end
    end

    // Read data, GPIO, status flag and the two-flop gpio_in synchronizer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_rd_data_q  <= '0;
            gpio_out_q   <= '0;
            bad_addr_q   <= 1'b0;
            gpio_sync1_q <= '0;
            gpio_sync2_q <= '0;
        end else begin
            d_rd_data_q  <= d_rd_data_d;
            gpio_out_q   <= gpio_out_d;
            bad_addr_q   <= bad_addr_d;
            gpio_sync1_q <= gpio_in;
            gpio_sync2_q <= gpio_sync1_q;
        end
    end

`ifdef DMEM_TIMER_EN
    // Machine timer, compare value, HI snapshot and registered interrupt.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtime_q           <= '0;
            mtimecmp_q        <= '1;
            mtime_hi_shadow_q <= '0;
            timer_irq_q       <= 1'b0;
        end else begin
            mtime_q           <= mtime_d;
            mtimecmp_q        <= mtimecmp_d;
            mtime_hi_shadow_q <= mtime_hi_shadow_d;
            timer_irq_q       <= timer_irq_d;
        end
    end

    assign timer_irq = timer_irq_q;
`else
    assign timer_irq = 1'b0;
`endif

    assign bus.d_rd_data = d_rd_data_q;
    assign gpio_out      = gpio_out_q;
    assign bad_addr      = bad_addr_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder. Each access pushes its expected
// read data onto a scoreboard queue; the entry is popped and compared when
// the registered read data appears one cycle later.
module tb_dmem_responder;

    localparam int unsigned DEPTH_WORDS = 1024;
    localparam logic [31:0] MMIO        = 32'h8000_0000;
    localparam logic [31:0] A_GPIO_OUT  = MMIO + 32'h00;
    localparam logic [31:0] A_GPIO_IN   = MMIO + 32'h04;
    localparam logic [31:0] A_MTIME_LO  = MMIO + 32'h08;
    localparam logic [31:0] A_MTIME_HI  = MMIO + 32'h0C;
    localparam logic [31:0] A_CMP_LO    = MMIO + 32'h10;
    localparam logic [31:0] A_CMP_HI    = MMIO + 32'h14;
    localparam logic [31:0] A_STATUS    = MMIO + 32'h18;
    localparam logic [31:0] A_HOLE      = MMIO + 32'h1C;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] data;
        logic [31:0] exp_rd;
        bit          chk_rd;
        logic        exp_bad;
    } txn_t;

    logic        clk;
    logic        rst;
    logic [31:0] gpio_in;
    logic [31:0] gpio_out;
    logic        timer_irq;
    logic        bad_addr;

    int checks;
    int errors;

    txn_t        plan[$];
    logic [31:0] sb_q[$];

    dmem_responder_if bus_if ();

    dmem_responder #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .MMIO_BASE  (MMIO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus_if),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .timer_irq(timer_irq),
        .bad_addr (bad_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one access from a negedge, record its expected read data, and
    // return at the next negedge when the registered result is visible.
    task automatic step(input txn_t t);
        bus_if.d_addr    = t.addr;
        bus_if.d_we      = t.we;
        bus_if.d_wr_data = t.data;
        if (t.chk_rd) sb_q.push_back(t.exp_rd);
        @(negedge clk);
        bus_if.d_addr = 32'h0;
        bus_if.d_we   = 4'h0;
    endtask

    task automatic test_reset();
        logic [31:0] exp;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus_if.d_rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd got %h want 0", bus_if.d_rd_data); end
        checks++; if (gpio_out !== 32'h0) begin errors++; $display("FAIL reset_gpio got %h want 0", gpio_out); end
        checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", timer_irq); end
        checks++; if (bad_addr !== 1'b0) begin errors++; $display("FAIL reset_bad got %b want 0", bad_addr); end
        rst = 1'b1;
        step('{32'h40, 4'hF, 32'h0000_AAAA, 32'h0, 1'b0, 1'b0});
        step('{A_GPIO_OUT, 4'hF, 32'h0000_1234, 32'h0, 1'b0, 1'b0});
        // Reset lands in the middle of a RAM write.
        bus_if.d_addr    = 32'h40;
        bus_if.d_we      = 4'hF;
        bus_if.d_wr_data = 32'h0000_5555;
        rst = 1'b0;
        #1;
        checks++; if (gpio_out !== 32'h0) begin errors++; $display("FAIL async_reset_gpio got %h want 0", gpio_out); end
        @(negedge clk);
        bus_if.d_we = 4'h0;
        rst = 1'b1;
        step('{32'h40, 4'h0, 32'h0, 32'h0000_AAAA, 1'b1, 1'b0});
        exp = sb_q.pop_front();
        checks++; if (bus_if.d_rd_data !== exp) begin errors++; $display("FAIL reset_write_dropped got %h want %h", bus_if.d_rd_data, exp); end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] exp;
        plan = {};
        plan.push_back('{32'h10, 4'hF,    32'hDEAD_BEEF, 32'h0,         1'b0, 1'b0});
        plan.push_back('{32'h10, 4'b0010, 32'h0000_5500, 32'hDEAD_BEEF, 1'b1, 1'b0});
        plan.push_back('{32'h10, 4'h0,    32'h0,         32'hDEAD_55EF, 1'b1, 1'b0});
        plan.push_back('{32'h14, 4'hF,    32'h1122_3344, 32'h0,         1'b0, 1'b0});
        plan.push_back('{32'h14, 4'b1001, 32'hAABB_CCDD, 32'h1122_3344, 1'b1, 1'b0});
        plan.push_back('{32'h14, 4'h0,    32'h0,         32'hAA22_33DD, 1'b1, 1'b0});
        foreach (plan[i]) begin
            step(plan[i]);
            if (plan[i].chk_rd) begin
                exp = sb_q.pop_front();
                checks++;
                if (bus_if.d_rd_data !== exp) begin errors++; $display("FAIL byte_lanes[%0d] rd got %h want %h", i, bus_if.d_rd_data, exp); end
            end
            checks++;
            if (bad_addr !== plan[i].exp_bad) begin errors++; $display("FAIL byte_lanes_bad[%0d] got %b want %b", i, bad_addr, plan[i].exp_bad); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        plan = {};
        plan.push_back('{32'h20, 4'hF, 32'h0, 32'h0, 1'b0, 1'b0});
        plan.push_back('{32'h20, 4'hF, 32'h1, 32'h0, 1'b1, 1'b0});
        plan.push_back('{32'h20, 4'h0, 32'h0, 32'h1, 1'b1, 1'b0});
        plan.push_back('{32'h24, 4'hF, 32'h2, 32'h0, 1'b0, 1'b0});
        plan.push_back('{32'h20, 4'h0, 32'h0, 32'h1, 1'b1, 1'b0});
        plan.push_back('{32'h24, 4'h0, 32'h0, 32'h2, 1'b1, 1'b0});
        foreach (plan[i]) begin
            step(plan[i]);
            if (plan[i].chk_rd) begin
                exp = sb_q.pop_front();
                checks++;
                if (bus_if.d_rd_data !== exp) begin errors++; $display("FAIL back_to_back[%0d] rd got %h want %h", i, bus_if.d_rd_data, exp); end
            end
            checks++;
            if (bad_addr !== plan[i].exp_bad) begin errors++; $display("FAIL back_to_back_bad[%0d] got %b want %b", i, bad_addr, plan[i].exp_bad); end
        end
    endtask

    task automatic test_ram_boundary();
        logic [31:0] exp;
        logic [31:0] last_word;
        last_word = DEPTH_WORDS * 4 - 4;
        plan = {};
        plan.push_back('{32'h0,         4'hF, 32'h1357_9BDF, 32'h0,         1'b0, 1'b0});
        plan.push_back('{last_word,     4'hF, 32'hCAFE_F00D, 32'h0,         1'b0, 1'b0});
        plan.push_back('{last_word,     4'h0, 32'h0,         32'hCAFE_F00D, 1'b1, 1'b0});
        plan.push_back('{last_word + 4, 4'hF, 32'h7777_7777, 32'h0,         1'b1, 1'b1});
        plan.push_back('{32'h0,         4'h0, 32'h0,         32'h1357_9BDF, 1'b1, 1'b1});
        plan.push_back('{A_STATUS,      4'h0, 32'h0,         32'h1,         1'b1, 1'b1});
        plan.push_back('{A_STATUS,      4'h1, 32'h1,         32'h1,         1'b1, 1'b0});
        plan.push_back('{A_STATUS,      4'h0, 32'h0,         32'h0,         1'b1, 1'b0});
        foreach (plan[i]) begin
            step(plan[i]);
            if (plan[i].chk_rd) begin
                exp = sb_q.pop_front();
                checks++;
                if (bus_if.d_rd_data !== exp) begin errors++; $display("FAIL ram_boundary[%0d] rd got %h want %h", i, bus_if.d_rd_data, exp); end
            end
            checks++;
            if (bad_addr !== plan[i].exp_bad) begin errors++; $display("FAIL ram_boundary_bad[%0d] got %b want %b", i, bad_addr, plan[i].exp_bad); end
        end
    endtask

    task automatic test_bad_addr();
        logic [31:0] exp;
        plan = {};
        plan.push_back('{32'h4000_0000, 4'h0,    32'h0,         32'h0, 1'b1, 1'b1});
        plan.push_back('{A_STATUS,      4'b0010, 32'h0000_0001, 32'h1, 1'b1, 1'b1});
        plan.push_back('{A_STATUS,      4'h1,    32'h0000_0002, 32'h1, 1'b1, 1'b1});
        plan.push_back('{A_STATUS,      4'h1,    32'h0000_0001, 32'h1, 1'b1, 1'b0});
        plan.push_back('{A_HOLE,        4'h0,    32'h0,         32'h0, 1'b1, 1'b1});
        plan.push_back('{A_STATUS,      4'hF,    32'hFFFF_FFFF, 32'h1, 1'b1, 1'b0});
        plan.push_back('{A_GPIO_IN,     4'hF,    32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0});
        foreach (plan[i]) begin
            step(plan[i]);
            if (plan[i].chk_rd) begin
                exp = sb_q.pop_front();
                checks++;
                if (bus_if.d_rd_data !== exp) begin errors++; $display("FAIL bad_addr[%0d] rd got %h want %h", i, bus_if.d_rd_data, exp); end
            end
            checks++;
            if (bad_addr !== plan[i].exp_bad) begin errors++; $display("FAIL bad_addr_flag[%0d] got %b want %b", i, bad_addr, plan[i].exp_bad); end
        end
    endtask

    task automatic test_gpio();
        logic [31:0] exp;
        plan = {};
        plan.push_back('{A_GPIO_OUT, 4'hF,    32'h1234_5678, 32'h0,         1'b1, 1'b0});
        plan.push_back('{A_GPIO_OUT, 4'b1000, 32'hAB00_0000, 32'h1234_5678, 1'b1, 1'b0});
        plan.push_back('{A_GPIO_OUT, 4'h0,    32'h0,         32'hAB34_5678, 1'b1, 1'b0});
        plan.push_back('{A_GPIO_IN,  4'h0,    32'h0,         32'h0,         1'b1, 1'b0});
        plan.push_back('{A_GPIO_IN,  4'h0,    32'h0,         32'h0,         1'b1, 1'b0});
        plan.push_back('{A_GPIO_IN,  4'h0,    32'h0,         32'hA5A5_0000, 1'b1, 1'b0});
        foreach (plan[i]) begin
            if (i == 3) gpio_in = 32'hA5A5_0000;
            step(plan[i]);
            if (plan[i].chk_rd) begin
                exp = sb_q.pop_front();
                checks++;
                if (bus_if.d_rd_data !== exp) begin errors++; $display("FAIL gpio[%0d] rd got %h want %h", i, bus_if.d_rd_data, exp); end
            end
            checks++;
            if (bad_addr !== plan[i].exp_bad) begin errors++; $display("FAIL gpio_bad[%0d] got %b want %b", i, bad_addr, plan[i].exp_bad); end
        end
        checks++;
        if (gpio_out !== 32'hAB34_5678) begin errors++; $display("FAIL gpio_out_pins got %h want ab345678", gpio_out); end
    endtask

`ifdef DMEM_TIMER_EN
    task automatic test_timer_irq();
        logic [31:0] exp;
        logic        exp_irq;
        plan = {};
        plan.push_back('{A_CMP_HI,   4'hF, 32'h0,  32'hFFFF_FFFF, 1'b1, 1'b0});
        plan.push_back('{A_CMP_LO,   4'hF, 32'd50, 32'hFFFF_FFFF, 1'b1, 1'b0});
        plan.push_back('{A_MTIME_HI, 4'hF, 32'h0,  32'h0,         1'b0, 1'b0});
        plan.push_back('{A_MTIME_LO, 4'hF, 32'd40, 32'h0,         1'b0, 1'b0});
        foreach (plan[i]) begin
            step(plan[i]);
            if (plan[i].chk_rd) begin
                exp = sb_q.pop_front();
                checks++;
                if (bus_if.d_rd_data !== exp) begin errors++; $display("FAIL timer_cmp[%0d] rd got %h want %h", i, bus_if.d_rd_data, exp); end
            end
        end
        for (int k = 1; k <= 14; k++) begin
            step('{A_CMP_LO, 4'h0, 32'h0, 32'd50, 1'b1, 1'b0});
            exp = sb_q.pop_front();
            checks++;
            if (bus_if.d_rd_data !== exp) begin errors++; $display("FAIL timer_cmp_rd[%0d] got %h want %h", k, bus_if.d_rd_data, exp); end
            exp_irq = (40 + k - 1) >= 50;
            checks++;
            if (timer_irq !== exp_irq) begin errors++; $display("FAIL timer_irq_rise[%0d] got %b want %b", k, timer_irq, exp_irq); end
        end
        step('{A_CMP_LO, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0});
        checks++; if (timer_irq !== 1'b1) begin errors++; $display("FAIL timer_irq_lag got %b want 1", timer_irq); end
        step('{32'h0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0});
        checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL timer_irq_fall got %b want 0", timer_irq); end
    endtask

    task automatic test_timer_snapshot();
        logic [31:0] exp;
        plan = {};
        plan.push_back('{A_MTIME_HI, 4'hF, 32'h0,         32'h0,         1'b0, 1'b0});
        plan.push_back('{A_MTIME_LO, 4'hF, 32'hFFFF_FFFE, 32'h0,         1'b0, 1'b0});
        plan.push_back('{A_MTIME_LO, 4'h0, 32'h0,         32'hFFFF_FFFE, 1'b1, 1'b0});
        plan.push_back('{A_MTIME_HI, 4'h0, 32'h0,         32'h0,         1'b1, 1'b0});
        plan.push_back('{A_MTIME_LO, 4'h0, 32'h0,         32'h0,         1'b1, 1'b0});
        plan.push_back('{A_MTIME_HI, 4'h0, 32'h0,         32'h1,         1'b1, 1'b0});
        foreach (plan[i]) begin
            step(plan[i]);
            if (plan[i].chk_rd) begin
                exp = sb_q.pop_front();
                checks++;
                if (bus_if.d_rd_data !== exp) begin errors++; $display("FAIL timer_snapshot[%0d] rd got %h want %h", i, bus_if.d_rd_data, exp); end
            end
        end
    endtask
`else
    task automatic test_timer_disabled();
        logic [31:0] exp;
        plan = {};
        plan.push_back('{A_MTIME_LO, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1});
        plan.push_back('{A_STATUS,   4'h1, 32'h1, 32'h1, 1'b1, 1'b0});
        plan.push_back('{A_CMP_HI,   4'hF, 32'h5, 32'h0, 1'b1, 1'b1});
        plan.push_back('{A_STATUS,   4'h1, 32'h1, 32'h1, 1'b1, 1'b0});
        foreach (plan[i]) begin
            step(plan[i]);
            if (plan[i].chk_rd) begin
                exp = sb_q.pop_front();
                checks++;
                if (bus_if.d_rd_data !== exp) begin errors++; $display("FAIL timer_off[%0d] rd got %h want %h", i, bus_if.d_rd_data, exp); end
            end
            checks++;
            if (bad_addr !== plan[i].exp_bad) begin errors++; $display("FAIL timer_off_bad[%0d] got %b want %b", i, bad_addr, plan[i].exp_bad); end
        end
        checks++;
        if (timer_irq !== 1'b0) begin errors++; $display("FAIL timer_off_irq got %b want 0", timer_irq); end
    endtask
`endif

    initial begin
        checks           = 0;
        errors           = 0;
        rst              = 1'b0;
        gpio_in          = 32'h0;
        bus_if.d_addr    = 32'h0;
        bus_if.d_we      = 4'h0;
        bus_if.d_wr_data = 32'h0;
        test_reset();
        test_byte_lanes();
        test_back_to_back();
        test_ram_boundary();
        test_bad_addr();
        test_gpio();
`ifdef DMEM_TIMER_EN
        test_timer_irq();
        test_timer_snapshot();
`else
        test_timer_disabled();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-side memory responder for the single-cycle core's data port. Decodes every `d_addr`, serves a word-addressed RAM with byte-lane writes and a small MMIO window (GPIO, 64-bit machine timer, status), and returns registered read data one cycle after the address. Sits directly between the core's data port and the board pins/interrupt line.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024: RAM size in 32-bit words (power of two); RAM occupies `0x0` to `DEPTH_WORDS*4-1`.
- `MMIO_BASE`, 32'h8000_0000: base of MMIO window (64-byte aligned, 64-byte span).

Ports:
- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  reset; one clock, reset asynchronous active-low (asserted at 0).
- `d_addr`  in  32  byte address from core; bits [1:0] ignored.
- `d_we`  in  4  byte-lane write enables; lane i writes `d_wr_data[8i+7:8i]`; 0 = read.
- `d_wr_data`  in  32  lane-aligned write data.
- `d_rd_data`  out  32  registered read data.
- `gpio_in`  in  32  asynchronous input pins.
- `gpio_out`  out  32  output register.
- `timer_irq`  out  1  registered `mtime >= mtimecmp`.
- `bad_addr`  out  1  sticky unmapped-access flag.

## Operation
- Decode per cycle: RAM hit if `d_addr < DEPTH_WORDS*4`; MMIO hit if `d_addr[31:6] == MMIO_BASE[31:6]` and offset mapped; else unmapped.
- MMIO offsets: 0x00 GPIO_OUT (RW); 0x04 GPIO_IN (RO, 2-flop synchronized); 0x08 MTIME_LO; 0x0C MTIME_HI; 0x10 MTIMECMP_LO; 0x14 MTIMECMP_HI; 0x18 STATUS (bit0 = `bad_addr`, write-1-to-clear via lane 0; other bits read 0).
- RAM: every cycle reads word `d_addr[log2(DEPTH_WORDS)+1:2]`; writes enabled lanes at edge. Read-first: same-cycle read of written word returns old data.
- MMIO writes honour byte lanes on RW registers; writes to RO offsets ignored (no fault).
- Unmapped access (read or any `d_we`): reads return 0, writes dropped, `bad_addr` set at edge.
- `mtime`: 64-bit, +1 every cycle, wraps 2^64-1 -> 0. Write to MTIME_LO/HI replaces written lanes of that half; no increment that cycle; increments resume next cycle.
- Snapshot: read of MTIME_LO captures `mtime[63:32]` into `mtime_hi_shadow`; MTIME_HI read returns shadow, giving coherent 64-bit LO-then-HI reads.
- `timer_irq` level, cleared only by raising `mtimecmp` or lowering `mtime`.
- `bad_addr` set and W1C in same cycle: set wins.

## Timing
- Read latency 1: `d_rd_data` during cycle N+1 reflects address presented in cycle N (matches core `ld_en`/`ld_valid` pairing). Held when no new address? No: updated every cycle from current `d_addr`.
- Write latency 0: committed at the edge ending the cycle `d_we` is asserted; visible to read issued next cycle.
- MMIO read of MTIME_LO returns value before that edge's increment.
- `timer_irq` lags compare inputs by 1 cycle; `mtimecmp` write at edge N -> `timer_irq` updated at edge N+1.
- `gpio_in` to readable value: 2 cycles synchronizer + 1 read latency.
- Reset values: `d_rd_data`=0, `gpio_out`=0, `timer_irq`=0, `bad_addr`=0, `mtime`=0, `mtimecmp`=all-ones, shadow=0, synchronizer=0. RAM contents not reset.
- Reset asserted mid-write: write on that edge dropped; outputs go to reset values asynchronously.

## Configuration
- `DMEM_TIMER_EN`: defined -> `mtime`, `mtimecmp`, shadow and `timer_irq` logic present. Undefined -> offsets 0x08–0x14 unmapped (read 0, set `bad_addr`), `timer_irq` tied 0, no timer flops.

## Test plan
- Write 0xDEADBEEF to 0x10 with `d_we`=4'hF, then `d_we`=4'b0010 data 0x0000_5500 -> read 0x10 next cycle returns 0xDEAD55EF one cycle later.
- Same cycle write 0x1 and read 0x20 (word holds 0x0) -> `d_rd_data`=0x0 next cycle; following read returns 0x1.
- Write MTIMECMP_HI=0, MTIMECMP_LO=50 after reset -> `timer_irq` rises on the cycle `mtime` reaches 50 plus 1; write MTIMECMP_LO=0xFFFF_FFFF -> `timer_irq` low 1 cycle later.
- Write MTIME_LO=0xFFFF_FFFE, MTIME_HI=0; read LO then HI across carry -> LO=0xFFFF_FFFF-ish, HI=shadow 0 (no tearing).
- Read 0x4000_0000 -> `d_rd_data`=0, `bad_addr`=1; write 0x1 to STATUS -> `bad_addr`=0; simultaneous unmapped access + clear -> stays 1.
- Drive `gpio_in`=0xA5A5_0000, read GPIO_IN immediately -> 0; after 2 cycles -> 0xA5A5_0000; undefined `DMEM_TIMER_EN`: read MTIME_LO -> 0 and `bad_addr`=1.
